// File: rtl/mem_stage_dmem.sv
// mem_stage_dmem: multi-cycle data memory for the MEM stage, stalling the pipeline until each access completes.
// Defining MEM_ALIGN_CHECK_EN adds misalign_o and rejects accesses whose addr_i[1:0] is nonzero.
module mem_stage_dmem #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W = 8,
  parameter int LATENCY = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        memread_i,
  input  logic        memwrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        stall_o
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic        misalign_o
`endif
);
  localparam int CNT_W = LATENCY > 1 ? $clog2(LATENCY) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic op_wr;
  logic [ADDR_W-1:0] idx;
  logic [31:0] wdata_q;
  logic [31:0] mem [DEPTH_WORDS];
  logic req, access, bad, unused_addr;
  assign req = memread_i | memwrite_i;
  assign access = state == BUSY && cnt == '0;
  assign stall_o = state == BUSY || (state == IDLE && req);
  assign unused_addr = ^{addr_i[31:ADDR_W+2], addr_i[1:0]};
`ifdef MEM_ALIGN_CHECK_EN
  assign bad = addr_i[1:0] != 2'b00;
`else
  assign bad = 1'b0;
`endif
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      rdata_o <= '0;
      op_wr   <= 1'b0;
      idx     <= '0;
      wdata_q <= '0;
`ifdef MEM_ALIGN_CHECK_EN
      misalign_o <= 1'b0;
`endif
    end else begin
`ifdef MEM_ALIGN_CHECK_EN
      misalign_o <= state == IDLE && req && bad;
`endif
      if (state == IDLE && req) begin
        op_wr   <= memwrite_i;
        idx     <= addr_i[ADDR_W+1:2];
        wdata_q <= wdata_i;
        cnt     <= CNT_W'(LATENCY - 1);
        state   <= bad ? DONE : BUSY;
      end else if (state == BUSY) begin
        if (cnt != '0) cnt <= cnt - 1'b1;
        if (access) begin
          if (!op_wr) rdata_o <= mem[idx];
          state <= DONE;
        end
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
  end
  // storage is deliberately outside the reset domain; an aborted store never reaches it
  always_ff @(posedge clk_i)
    if (!rst_i && access && op_wr) mem[idx] <= wdata_q;
endmodule

// File: tb/tb_mem_stage_dmem.sv
// tb_mem_stage_dmem: directed scoreboard bench; stimulus queues expected releases, a negedge monitor checks them.
module tb_mem_stage_dmem;
  localparam int L = 3;
  logic clk_i = 1'b0;
  logic rst_i, memread_i, memwrite_i;
  logic [31:0] addr_i, wdata_i, rdata_o;
  logic stall_o;
`ifdef MEM_ALIGN_CHECK_EN
  logic misalign_o;
`endif
  typedef struct {int stalls; logic [31:0] rd; logic mis;} exp_t;
  exp_t expq[$];
  exp_t e;
  int checks = 0;
  int failures = 0;
  int scnt = 0;

  mem_stage_dmem #(.DEPTH_WORDS(256), .ADDR_W(8), .LATENCY(L)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .memread_i(memread_i), .memwrite_i(memwrite_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .stall_o(stall_o)
`ifdef MEM_ALIGN_CHECK_EN
    , .misalign_o(misalign_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (rst_i) scnt = 0;
    else if (stall_o) scnt++;
    else if (scnt != 0) begin
      if (expq.size() == 0) chk("unexpected_release", 32'(scnt), 32'd0);
      else begin
        e = expq.pop_front();
        chk("stall_cycles", 32'(scnt), 32'(e.stalls));
        chk("rdata_at_release", rdata_o, e.rd);
`ifdef MEM_ALIGN_CHECK_EN
        chk("misalign_at_release", 32'(misalign_o), 32'(e.mis));
`endif
      end
      scnt = 0;
    end
`ifdef MEM_ALIGN_CHECK_EN
    else if (!rst_i) chk("misalign_idle", 32'(misalign_o), 32'd0);
`endif
  end

  task automatic do_req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] busy_a, input logic [31:0] exp_rd, input int exp_st,
                        input logic exp_mis);
    int n;
    expq.push_back('{exp_st, exp_rd, exp_mis});
    @(posedge clk_i); #1;
    memread_i = rd; memwrite_i = wr; addr_i = a; wdata_i = wd;
    n = 0;
    do begin
      @(posedge clk_i); #1;
      addr_i = busy_a; wdata_i = ~wd; n++;
    end while (stall_o && n < 20);
    if (stall_o) chk("release_timeout", 32'(n), 32'(exp_st));
    memread_i = 1'b0; memwrite_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; memread_i = 1'b1; memwrite_i = 1'b0; addr_i = 32'h10; wdata_i = '0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0; memread_i = 1'b0;
    @(negedge clk_i);
    chk("reset_rdata", rdata_o, 32'd0);
    chk("reset_stall", 32'(stall_o), 32'd0);
    do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h10, 32'h0, L + 1, 1'b0);
    do_req(1'b1, 1'b0, 32'h10, 32'h0, 32'h10, 32'hDEADBEEF, L + 1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      chk("hold_rdata", rdata_o, 32'hDEADBEEF);
      chk("hold_stall", 32'(stall_o), 32'd0);
    end
    do_req(1'b0, 1'b1, 32'h20, 32'h11111111, 32'h20, 32'hDEADBEEF, L + 1, 1'b0);
    do_req(1'b0, 1'b1, 32'h24, 32'h22222222, 32'h24, 32'hDEADBEEF, L + 1, 1'b0);
    do_req(1'b1, 1'b0, 32'h20, 32'h0, 32'h24, 32'h11111111, L + 1, 1'b0);
    do_req(1'b1, 1'b1, 32'h30, 32'h5A5A5A5A, 32'h30, 32'h11111111, L + 1, 1'b0);
    do_req(1'b1, 1'b0, 32'h30, 32'h0, 32'h30, 32'h5A5A5A5A, L + 1, 1'b0);
    do_req(1'b0, 1'b1, 32'h400, 32'hCAFEF00D, 32'h400, 32'h5A5A5A5A, L + 1, 1'b0);
    do_req(1'b1, 1'b0, 32'h000, 32'h0, 32'h000, 32'hCAFEF00D, L + 1, 1'b0);
    do_req(1'b0, 1'b1, 32'h44, 32'h44444444, 32'h44, 32'hCAFEF00D, L + 1, 1'b0);
    @(posedge clk_i); #1;
    memwrite_i = 1'b1; addr_i = 32'h44; wdata_i = 32'h99999999;
    @(posedge clk_i); #1 memwrite_i = 1'b0;
    repeat (L - 1) @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(posedge clk_i); #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("midop_reset_rdata", rdata_o, 32'd0);
    chk("midop_reset_stall", 32'(stall_o), 32'd0);
    do_req(1'b1, 1'b0, 32'h44, 32'h0, 32'h44, 32'h44444444, L + 1, 1'b0);
`ifdef MEM_ALIGN_CHECK_EN
    do_req(1'b1, 1'b0, 32'h13, 32'h0, 32'h13, 32'h44444444, 1, 1'b1);
    do_req(1'b1, 1'b0, 32'h10, 32'h0, 32'h10, 32'hDEADBEEF, L + 1, 1'b0);
`endif
    repeat (3) @(posedge clk_i);
    chk("scoreboard_drained", 32'(expq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
